// File: rtl/cla_multiword_seq.sv
// Multi-word add sequencer: one WIDTH-bit carry-lookahead adder reused across WORDS words, LSW first.
// Optional subtract mode via `define CLA_SEQ_SUB_EN (adds in_sub port); default build is add only.

module cla_generator #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_carry,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);
  localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] g, p, gg, pp, ng, np, c;

  // Kogge-Stone prefix: gg[i]/pp[i] become group generate/propagate over bits [i:0].
  always_comb begin
    g  = in_a & in_b;
    p  = in_a ^ in_b;
    gg = g;
    pp = p;
    ng = g;
    np = p;
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      ng = gg;
      np = pp;
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= (1 << lvl)) begin
          ng[i] = gg[i] | (pp[i] & gg[i - (1 << lvl)]);
          np[i] = pp[i] & pp[i - (1 << lvl)];
        end
      end
      gg = ng;
      pp = np;
    end
    c    = '0;
    c[0] = in_carry;
    for (int i = 1; i < WIDTH; i++) begin
      c[i] = gg[i-1] | (pp[i-1] & in_carry);
    end
    sum   = p ^ c;
    carry = gg[WIDTH-1] | (pp[WIDTH-1] & in_carry);
  end
endmodule

module cla_multiword_seq #(
  parameter int WIDTH = 32,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] in_a,
  input  logic [WIDTH*WORDS-1:0] in_b,
  input  logic                   in_carry,
`ifdef CLA_SEQ_SUB_EN
  input  logic                   in_sub,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] out_sum,
  output logic                   out_carry,
  output logic                   busy,
  output logic [1:0]             dbg_state_o
);
  localparam int TW = WIDTH * WORDS;
  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready, and in_valid is ignored while in_ready is low.

  state_e         state_q, state_d;
  logic [TW-1:0]  a_q, a_d, b_q, b_d;
  logic           carry_q, carry_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [TW-1:0]  out_sum_q, out_sum_d;
  logic           out_carry_q, out_carry_d;

  logic [WIDTH-1:0] cla_a, cla_b, cla_sum;
  logic             cla_carry;
  logic             sub_sel;

`ifdef CLA_SEQ_SUB_EN
  assign sub_sel = in_sub;
`else
  assign sub_sel = 1'b0;
`endif

  assign cla_a = a_q[idx_q*WIDTH +: WIDTH];
  assign cla_b = b_q[idx_q*WIDTH +: WIDTH];

  cla_generator #(.WIDTH(WIDTH)) u_cla (
    .in_a     (cla_a),
    .in_b     (cla_b),
    .in_carry (carry_q),
    .sum      (cla_sum),
    .carry    (cla_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      out_sum_q   <= '0;
      out_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      out_sum_q   <= out_sum_d;
      out_carry_q <= out_carry_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    out_sum_d   = out_sum_q;
    out_carry_d = out_carry_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Subtraction stored as A + ~B + ~cin so the datapath stays add-only.
          a_d     = in_a;
          b_d     = sub_sel ? ~in_b : in_b;
          carry_d = sub_sel ? ~in_carry : in_carry;
          idx_d   = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        out_sum_d[idx_q*WIDTH +: WIDTH] = cla_sum;
        carry_d = cla_carry;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          out_carry_d = cla_carry;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign out_sum     = out_sum_q;
  assign out_carry   = out_carry_q;
  assign dbg_state_o = state_q;
endmodule
